// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and default sizes for the data-memory arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 10;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    typedef enum logic {
        PRI_CPU = 1'b0,
        PRI_DBG = 1'b1
    } pri_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve.sv
// ============================================================================
// dmem_arb_starve : saturating count of cycles the debug port was refused
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic dbg_req_i,
    input  logic dbg_gnt_i,
    output logic limit_hit_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!dbg_req_i || dbg_gnt_i) begin
            count_d = 4'd0;
        end else if (count_q != 4'hF) begin
            count_d = count_q + 4'd1;
        end
    end

    // Fires on the edge that moves the count onto the limit.
    assign limit_hit_o = (count_d == 4'(STARVE_LIMIT));

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port (CPU / debug) arbiter onto one synchronous data RAM
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    pri_e              pri_q, pri_d;
    logic              rd_pend_q, rd_pend_d;
    req_id_e           rd_id_q, rd_id_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              starve_hit;

    dmem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock_i     (clock),
        .reset_ni    (reset_n),
        .dbg_req_i   (dbg_req),
        .dbg_gnt_i   (dbg_gnt),
        .limit_hit_o (starve_hit)
    );

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (reset_n) begin
            if (dbg_hold) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                if (pri_q == PRI_DBG) begin
                    dbg_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = dbg_gnt ? dbg_we    : (cpu_gnt & cpu_we);
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

    always_comb begin
        pri_d = pri_q;
        if (dbg_gnt) begin
            pri_d = PRI_CPU;
        end else if (starve_hit) begin
            pri_d = PRI_DBG;
        end
    end

    // Remember who owns the read in flight; the other port may be granted next.
    assign rd_pend_d = mem_en & ~mem_we;
    assign rd_id_d   = dbg_gnt ? REQ_DBG : REQ_CPU;

    assign cpu_rvalid = rd_pend_q && (rd_id_q == REQ_CPU);
    assign dbg_rvalid = rd_pend_q && (rd_id_q == REQ_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pri_q       <= PRI_CPU;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= REQ_CPU;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            pri_q     <= pri_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, word address width of the shared data memory.
REQ-002 Parameter: DATA_W, 32, data word width.
REQ-003 Parameter: STARVE_LIMIT, 4, consecutive lost cycles after which the debug port gains priority (range 1-15).
REQ-004 clock  in  1  single clock, all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU access request / write-enable.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data.
REQ-008 cpu_gnt / cpu_rvalid  out  1 / 1  CPU access issued this cycle / CPU read data valid.
REQ-009 cpu_rdata  out  DATA_W  CPU read data.
REQ-010 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same widths/directions as CPU set  debug/loader port.
REQ-011 dbg_hold  in  1  debug owns memory exclusively (CPU halted).
REQ-012 mem_en / mem_we  out  1 / 1  memory access strobe / write.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-014 mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-015 Requester SHALL hold req, we, addr, wdata stable from assertion until the cycle its gnt is high; gnt high SHALL mean the access is issued that same cycle.
REQ-016 At most one gnt SHALL be high per cycle; mem_en SHALL equal cpu_gnt OR dbg_gnt, with mem_we/addr/wdata muxed from the granted port (combinational from req inputs and registered state).
REQ-017 Default priority: CPU wins when both request; priority state register PRI_CPU/PRI_DBG selects winner on conflict.
REQ-018 Starve counter (4 bits) SHALL increment each cycle dbg_req=1 and dbg_gnt=0, saturate at 15, clear when dbg_gnt=1 or dbg_req=0.
REQ-019 Priority SHALL move to PRI_DBG on the edge where counter reaches STARVE_LIMIT, and return to PRI_CPU on the edge after dbg_gnt=1.
REQ-020 dbg_hold=1 SHALL force cpu_gnt=0 regardless of priority; dbg requests granted every cycle.
REQ-021 Read latency: rvalid of the granted port SHALL be high exactly one cycle after a read gnt, rdata = mem_rdata that cycle; writes SHALL produce no rvalid.
REQ-022 Back-to-back accesses (one per cycle) SHALL be sustained with no bubble; issue order SHALL equal grant order, so write-then-read to one address returns the new data.
REQ-023 Requester id of an outstanding read SHALL be registered so rvalid routes correctly even if the other port is granted in the response cycle.
REQ-024 rdata of the non-responding port SHALL hold its last value; no request SHALL ever yield gnt.

Reset
REQ-025 reset_n low SHALL asynchronously clear: priority to PRI_CPU, starve counter to 0, outstanding-read flag to 0, both rvalid to 0, both rdata to 0.
REQ-026 gnt and mem_en SHALL be 0 while reset_n is low; a read granted in the cycle before reset SHALL produce no rvalid.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold requester-id enum (REQ_CPU=0, REQ_DBG=1), priority enum (PRI_CPU, PRI_DBG), and default ADDR_W/DATA_W/STARVE_LIMIT constants.
REQ-028 One sub-module dmem_arb_starve (saturating counter plus limit compare) SHALL be instantiated; all else flat.

Verification
REQ-029 CPU read addr 3 only, memory holds 0x0000002A -> cpu_gnt cycle N, cpu_rvalid cycle N+1, cpu_rdata=0x2A, dbg_* all idle.
REQ-030 Both requesting continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, dbg granted 5th cycle, CPU granted again 6th cycle.
REQ-031 dbg_hold=1, dbg writes 0x11/0x22 to addr 0/1 back-to-back while cpu_req=1 -> two dbg_gnt in consecutive cycles, cpu_gnt stays 0.
REQ-032 CPU write 0xDEAD to addr 5, then dbg read addr 5 next cycle -> dbg_rdata=0xDEAD, cpu_rvalid never high.
REQ-033 CPU read granted cycle N, dbg write granted cycle N+1 -> cpu_rvalid at N+1 with correct data, dbg_rvalid stays 0.
REQ-034 reset_n pulled low in cycle after read grant -> no rvalid, counter 0, priority PRI_CPU after release.
